axis_chirp_deframer: RTL and testbench
======================================

AXIS_CHIRP_DEFRAMER -- requirements
Module: axis_chirp_deframer

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, the sample/bin width in bits.
REQ-002 SHALL have parameter INDEX_WIDTH, default 16, the bin index width in bits.
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cfg_nfft, input, 4 bits: frame length = 1 << cfg_nfft.
REQ-006 SHALL have port cfg_nkeep, input, INDEX_WIDTH bits: bins kept per frame; 0 = keep all.
REQ-007 SHALL have port err_clear, input, 1 bit: clears sticky error flags.
REQ-008 SHALL have ports s_axis_tdata (input, AXIS_TDATA_WIDTH), s_axis_tvalid (input, 1), s_axis_tlast (input, 1) and s_axis_tready (output, 1): the FFT output stream.
REQ-009 SHALL have ports m_axis_tdata (output, AXIS_TDATA_WIDTH), m_axis_tuser (output, INDEX_WIDTH, bin index), m_axis_tvalid (output, 1), m_axis_tlast (output, 1) and m_axis_tready (input, 1).
REQ-010 SHALL have ports err_early and err_late, both output, 1 bit: sticky framing errors.

Function
REQ-011 SHALL count accepted slave beats (s_axis_tvalid & s_axis_tready) in bin index idx, from 0 to L-1 with L = 1 << cfg_nfft, then wrap to 0.
REQ-012 SHALL latch cfg_nfft and cfg_nkeep when the beat with idx = 0 is accepted, and hold them for the whole frame.
REQ-013 SHALL compute K = L if cfg_nkeep = 0 or cfg_nkeep >= L, and K = cfg_nkeep otherwise.
REQ-014 SHALL implement states PASS, DROP and RESYNC; reset state is PASS.
REQ-015 PASS SHALL forward each beat to the output with tdata unchanged, tuser = idx, and tlast = (idx = K-1); s_axis_tready SHALL equal the output buffer's ready.
REQ-016 PASS SHALL move to DROP after accepting idx = K-1 when K < L.
REQ-017 DROP SHALL hold s_axis_tready = 1, discard beats, and return to PASS after accepting idx = L-1.
REQ-018 If s_axis_tlast = 1 on an accepted beat with idx < L-1, the block SHALL set err_early, reset idx to 0 and enter PASS; a beat that is being forwarded SHALL leave with m_axis_tlast = 1.
REQ-019 If s_axis_tlast = 0 on an accepted beat with idx = L-1, the block SHALL set err_late and enter RESYNC.
REQ-020 RESYNC SHALL hold s_axis_tready = 1, discard beats up to and including the next beat with tlast, then enter PASS with idx = 0.
REQ-021 The output SHALL pass through a 2-entry skid buffer.
  - Latency: 1 cycle from slave acceptance to m_axis_tvalid.
  - Full throughput: one beat per cycle while m_axis_tready = 1.
  - No combinational path from m_axis_tready to s_axis_tready.
REQ-022 m_axis_tdata, m_axis_tuser and m_axis_tlast SHALL stay stable while m_axis_tvalid = 1 and m_axis_tready = 0.
REQ-023 err_clear SHALL clear err_early and err_late; if err_clear and an error event occur in the same cycle, the event wins.

Reset
REQ-024 Reset SHALL drive idx = 0, state = PASS, skid buffer empty, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tuser = 0, m_axis_tdata = 0, err_early = 0, err_late = 0 and s_axis_tready = 0.
REQ-025 s_axis_tready SHALL rise on the first clock edge after areset is released.
REQ-026 Reset asserted mid-frame SHALL discard all buffered beats; the next accepted beat is idx = 0.

Configuration
REQ-027 Macro CHIRP_DEFRAMER_FRAME_CNT_EN, when defined, SHALL add output frame_cnt[15:0].
  - Reset value 0.
  - Increments by 1, wrapping at 16 bits, when a beat with m_axis_tlast = 1 completes its handshake.
REQ-028 Without CHIRP_DEFRAMER_FRAME_CNT_EN, port frame_cnt and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Shared package axis_chirp_pkg SHALL hold the state encoding (PASS, DROP, RESYNC) and the cfg_nfft width constant (4), shared with the chirp framer.
REQ-030 The skid buffer SHALL be a separate sub-module, axis_skid_buffer, parameterised by total payload width (tdata + tuser + tlast).

Verification
REQ-031 cfg_nfft = 3, cfg_nkeep = 0, one 8-beat frame with tlast on beat 7, m_axis_tready = 1 -> 8 output beats, tuser 0..7, tlast only on tuser 7, each 1 cycle after input.
REQ-032 cfg_nfft = 4, cfg_nkeep = 5, one 16-beat frame -> output tuser 0..4 with tlast on 4; input beats 5..15 accepted and dropped.
REQ-033 cfg_nfft = 3, s_axis_tlast on beat 4 -> err_early = 1, output tlast on tuser 4; next beat goes out with tuser 0.
REQ-034 cfg_nfft = 2, no tlast on beat 3, tlast on beat 6 -> err_late = 1; beats 4..6 dropped; beat 7 goes out with tuser 0.
REQ-035 m_axis_tready toggling 1,0,0,1 during a frame -> no beat lost or duplicated, payload stable while stalled, s_axis_tready never depends combinationally on m_axis_tready.
REQ-036 areset asserted at idx = 3 of an 8-beat frame -> all outputs return to their reset values, then the next frame starts at tuser 0; with CHIRP_DEFRAMER_FRAME_CNT_EN defined, frame_cnt = 0 and then 1 after the next frame.

Source files
------------

// File: rtl/axis_chirp_pkg.sv
// axis_chirp_pkg
// Definitions shared by the chirp framer and deframer: the framing state
// encoding and the width of the cfg_nfft field (frame length = 1 << cfg_nfft).
package axis_chirp_pkg;

  localparam int CFG_NFFT_W = 4;

  typedef enum logic [1:0] {
    PASS   = 2'd0,  // forwarding the kept bins of a frame
    DROP   = 2'd1,  // discarding the bins past the keep count
    RESYNC = 2'd2   // frame overran its length; hunting for the next tlast
  } chirp_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer
// Two-entry AXI-Stream register slice. The upstream ready is a register, so
// there is no combinational path from m_ready_i to s_ready_o; the second
// entry absorbs the beat that arrives in the cycle the output stalls.
// Output payload only changes when the output register is empty or firing.
// Ports: clk_i/rst_i (async, active high); s_* upstream; m_* downstream;
//   W = total payload width.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [W-1:0] m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i
);

  logic [W-1:0] m_data_q, m_data_d, sk_data_q, sk_data_d;
  logic         m_valid_q, m_valid_d, sk_valid_q, sk_valid_d;
  logic         s_ready_q, s_ready_d;
  logic         s_fire, m_free;

  assign s_fire = s_valid_i & s_ready_q;
  assign m_free = ~m_valid_q | m_ready_i;

  always_comb begin
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    sk_data_d  = sk_data_q;
    sk_valid_d = sk_valid_q;
    if (m_free) begin
      // s_ready_q is low whenever the skid entry is full, so no new beat
      // can arrive while it drains.
      if (sk_valid_q) begin
        m_data_d   = sk_data_q;
        m_valid_d  = 1'b1;
        sk_valid_d = 1'b0;
      end else begin
        m_valid_d = s_fire;
        if (s_fire) m_data_d = s_data_i;
      end
    end else if (s_fire) begin
      sk_valid_d = 1'b1;
      sk_data_d  = s_data_i;
    end
    s_ready_d = ~sk_valid_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      sk_data_q  <= '0;
      sk_valid_q <= 1'b0;
      s_ready_q  <= 1'b0;
    end else begin
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      sk_data_q  <= sk_data_d;
      sk_valid_q <= sk_valid_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign s_ready_o = s_ready_q;
  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;

endmodule

// File: rtl/axis_chirp_deframer.sv
// axis_chirp_deframer
// Cuts the FFT output stream into frames of L = 1 << cfg_nfft bins, forwards
// the first K bins of each frame (K = cfg_nkeep, or L when 0 / >= L) with the
// bin index on tuser and tlast on the last kept bin, and drops the rest.
// A tlast before bin L-1 flags err_early and restarts the frame; a missing
// tlast on bin L-1 flags err_late and discards input up to the next tlast.
// Ports: aclk/areset (async, active high); cfg_nfft/cfg_nkeep, sampled on the
//   bin-0 beat and held for the frame; err_clear; s_axis_* FFT stream in;
//   m_axis_* kept bins out (tuser = bin index); err_early/err_late sticky.
// Optional: CHIRP_DEFRAMER_FRAME_CNT_EN adds frame_cnt[15:0], counting output
//   beats with tlast.
module axis_chirp_deframer
  import axis_chirp_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int INDEX_WIDTH      = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [CFG_NFFT_W-1:0]       cfg_nfft,
  input  logic [INDEX_WIDTH-1:0]      cfg_nkeep,
  input  logic                        err_clear,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [INDEX_WIDTH-1:0]      m_axis_tuser,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        err_early,
  output logic                        err_late
`ifdef CHIRP_DEFRAMER_FRAME_CNT_EN
  ,
  output logic [15:0]                 frame_cnt
`endif
);

  localparam int PW = AXIS_TDATA_WIDTH + INDEX_WIDTH + 1;

  chirp_state_e             state_q, state_d;
  logic [INDEX_WIDTH-1:0]   idx_q, idx_d;
  logic [CFG_NFFT_W-1:0]    nfft_q, nfft_d, nfft_eff;
  logic [INDEX_WIDTH-1:0]   nkeep_q, nkeep_d, nkeep_eff;
  logic                     err_early_q, err_early_d, err_late_q, err_late_d;
  logic                     ev_early, ev_late;

  logic [INDEX_WIDTH:0]     len, keep;   // L and K, one bit wider than idx
  logic                     at_last, at_keep, acc;
  logic                     skid_ready, fwd_valid, fwd_last;
  logic [PW-1:0]            m_pay;

  // Bin 0 uses the live config; later bins use what was latched on bin 0.
  assign nfft_eff  = (idx_q == '0) ? cfg_nfft  : nfft_q;
  assign nkeep_eff = (idx_q == '0) ? cfg_nkeep : nkeep_q;

  assign len     = {{INDEX_WIDTH{1'b0}}, 1'b1} << nfft_eff;
  assign keep    = (nkeep_eff == '0 || {1'b0, nkeep_eff} >= len) ? len : {1'b0, nkeep_eff};
  assign at_last = ({1'b0, idx_q} == len - 1'b1);
  assign at_keep = ({1'b0, idx_q} == keep - 1'b1);
  assign acc     = s_axis_tvalid & s_axis_tready;

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= PASS;
      idx_q       <= '0;
      nfft_q      <= '0;
      nkeep_q     <= '0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      nfft_q      <= nfft_d;
      nkeep_q     <= nkeep_d;
      err_early_q <= err_early_d;
      err_late_q  <= err_late_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ev_early = 1'b0;
    ev_late  = 1'b0;
    nfft_d   = (acc && idx_q == '0) ? cfg_nfft  : nfft_q;
    nkeep_d  = (acc && idx_q == '0) ? cfg_nkeep : nkeep_q;
    if (acc) begin
      unique case (state_q)
        PASS, DROP: begin
          if (s_axis_tlast && !at_last) begin
            ev_early = 1'b1;
            idx_d    = '0;
            state_d  = PASS;
          end else if (at_last) begin
            idx_d = '0;
            if (!s_axis_tlast) begin
              ev_late = 1'b1;
              state_d = RESYNC;
            end else begin
              state_d = PASS;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            if (state_q == PASS && at_keep) state_d = DROP;
          end
        end
        RESYNC: if (s_axis_tlast) state_d = PASS;  // idx already held at 0
        default: state_d = PASS;
      endcase
    end
    // An error event in the same cycle as err_clear keeps the flag set.
    err_early_d = ev_early | (err_early_q & ~err_clear);
    err_late_d  = ev_late  | (err_late_q  & ~err_clear);
  end

  // Outputs
  always_comb begin
    s_axis_tready = 1'b1;
    fwd_valid     = 1'b0;
    // An early tlast also terminates the forwarded frame.
    fwd_last      = at_keep | (s_axis_tlast & ~at_last);
    if (state_q == PASS) begin
      s_axis_tready = skid_ready;
      fwd_valid     = s_axis_tvalid;
    end
  end

  axis_skid_buffer #(.W(PW)) u_skid (
    .clk_i    (aclk),
    .rst_i    (areset),
    .s_data_i ({s_axis_tdata, idx_q, fwd_last}),
    .s_valid_i(fwd_valid),
    .s_ready_o(skid_ready),
    .m_data_o (m_pay),
    .m_valid_o(m_axis_tvalid),
    .m_ready_i(m_axis_tready)
  );

  assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = m_pay;
  assign err_early = err_early_q;
  assign err_late  = err_late_q;

`ifdef CHIRP_DEFRAMER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                                        frame_cnt_q <= '0;
    else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_axis_chirp_deframer.sv
// tb_axis_chirp_deframer
// Directed and randomized stimulus for axis_chirp_deframer; expected output
// beats and error flags come from a beat-stream reference model.
module tb_axis_chirp_deframer;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic [3:0]  cfg_nfft = '0;
  logic [15:0] cfg_nkeep = '0;
  logic        err_clear = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [15:0] m_axis_tuser;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic        err_early, err_late;
`ifdef CHIRP_DEFRAMER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  axis_chirp_deframer #(.AXIS_TDATA_WIDTH(32), .INDEX_WIDTH(16)) dut (
    .aclk(aclk), .areset(areset), .cfg_nfft(cfg_nfft), .cfg_nkeep(cfg_nkeep),
    .err_clear(err_clear),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .err_early(err_early), .err_late(err_late)
`ifdef CHIRP_DEFRAMER_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] d;
    logic [15:0] u;
    logic        l;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0, n_err = 0, n_out = 0, cyc = 0;
  int   pos = 0, mlen = 1, mkeep = 1, exp_fc = 0;
  bit   hunting = 0, m_early = 0, m_late = 0;
  int   mode = 0, pat = 0;
  bit   lat_chk = 1;
  bit   prev_stall = 0;
  logic [48:0] prev_pay;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: consumes every accepted input beat in order.
  task automatic model_accept(input logic [31:0] d, input logic l);
    exp_t x;
    if (err_clear) begin m_early = 0; m_late = 0; end
    if (hunting) begin
      if (l) hunting = 0;
    end else begin
      if (pos == 0) begin
        mlen  = 1 << cfg_nfft;
        mkeep = (cfg_nkeep == 0 || int'(cfg_nkeep) >= mlen) ? mlen : int'(cfg_nkeep);
      end
      if (pos < mkeep) begin
        x.d = d; x.u = 16'(pos); x.acc = cyc;
        x.l = (pos == mkeep - 1) || (l && pos < mlen - 1);
        exp_q.push_back(x);
      end
      if (l && pos < mlen - 1) begin m_early = 1; pos = 0; end
      else if (pos == mlen - 1) begin
        if (!l) begin m_late = 1; hunting = 1; end
        pos = 0;
      end else pos++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pos = 0; hunting = 0; m_early = 0; m_late = 0; exp_fc = 0;
  endtask

  // Advance one clock; update m_axis_tready according to the current mode.
  task automatic tick();
    logic r;
    @(posedge aclk); #1;
    case (mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = 1'($urandom_range(0, 1));
      2: begin
        m_axis_tready = (pat % 4 == 0) || (pat % 4 == 3);
        pat++;
        #1; r = s_axis_tready; m_axis_tready = ~m_axis_tready; #1;
        chk("ready_no_comb_path", s_axis_tready, r);
        m_axis_tready = ~m_axis_tready;
      end
      default: m_axis_tready = 1'b0;
    endcase
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    bit ok;
    n = 0; ok = 0;
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge aclk);
      if (s_axis_tready) begin model_accept(d, l); ok = 1; end
      tick();
      n++;
    end
    s_axis_tvalid = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  task automatic send_frame(input int n, input int last_at, input logic [31:0] base);
    for (int i = 0; i < n; i++) send(base + 32'(i), i == last_at);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 400) begin tick(); n++; end
    chk("drain_done", n < 400, 1);
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    areset = 1'b1;
    model_reset();
    #1;
    chk("rst_outputs", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                        m_axis_tdata, err_early, err_late}, '0);
`ifdef CHIRP_DEFRAMER_FRAME_CNT_EN
    chk("rst_frame_cnt", frame_cnt, 64'(exp_fc));
`endif
    tick(); tick();
    areset = 1'b0;
    #1;
    chk("ready_low_before_edge", s_axis_tready, 0);
    tick();
    chk("ready_after_release", s_axis_tready, 1);
  endtask

  // Output monitor: order, payload, latency and stall stability.
  always @(negedge aclk) begin
    if (areset) prev_stall = 0;
    else begin
      if (prev_stall)
        chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast},
            {1'b1, prev_pay});
      if (m_axis_tvalid && m_axis_tready) begin
        n_out++;
        chk("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_payload", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, {e.d, e.u, e.l});
          if (lat_chk) chk("out_latency", cyc, e.acc + 1);
        end
        if (m_axis_tlast) exp_fc++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_pay   = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n0, L, n, r;
    #1 areset = 1'b1;
    mode = 0;
    do_reset();

    // Full frame, keep all
    cfg_nfft = 4'd3; cfg_nkeep = 16'd0; n0 = n_out;
    send_frame(8, 7, 32'h100);
    drain();
    chk("full_frame_count", n_out - n0, 8);
    chk("full_frame_errs", {err_early, err_late}, {m_early, m_late});

    // Keep 5 of 16
    cfg_nfft = 4'd4; cfg_nkeep = 16'd5; n0 = n_out;
    send_frame(16, 15, 32'h200);
    drain();
    chk("keep5_count", n_out - n0, 5);
    chk("keep5_errs", {err_early, err_late}, {m_early, m_late});

    // Early tlast on beat 4, then a clean frame
    cfg_nfft = 4'd3; cfg_nkeep = 16'd0; n0 = n_out;
    send_frame(5, 4, 32'h300);
    chk("early_flag", {err_early, err_late}, {m_early, m_late});
    send_frame(8, 7, 32'h400);
    drain();
    chk("early_count", n_out - n0, 13);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    m_early = 0; m_late = 0;
    chk("clear_flags", {err_early, err_late}, {m_early, m_late});

    // Missing tlast: resync until beat 6, beat 7 restarts at bin 0
    cfg_nfft = 4'd2; n0 = n_out;
    send_frame(7, 6, 32'h500);
    send_frame(4, 3, 32'h600);
    drain();
    chk("late_flag", {err_early, err_late}, {m_early, m_late});
    chk("late_count", n_out - n0, 8);

    // Clear and early event in the same cycle: the event wins
    cfg_nfft = 4'd3;
    send(32'h700, 1'b0);
    err_clear = 1'b1;
    send(32'h701, 1'b1);
    err_clear = 1'b0;
    chk("clear_vs_event", {err_early, err_late}, {m_early, m_late});
    drain();
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    m_early = 0; m_late = 0;

    // Backpressure pattern 1,0,0,1
    mode = 2; pat = 0; lat_chk = 0; n0 = n_out;
    send_frame(8, 7, 32'h800);
    send_frame(8, 7, 32'h900);
    drain();
    chk("stall_count", n_out - n0, 16);

    // Randomized frames, config and backpressure
    mode = 1;
    for (int f = 0; f < 40; f++) begin
      cfg_nfft  = 4'($urandom_range(0, 4));
      cfg_nkeep = 16'($urandom_range(0, 20));
      L = 1 << cfg_nfft;
      r = int'($urandom_range(0, 7));
      n = (r == 0) ? int'($urandom_range(1, L)) : (r == 1) ? L + int'($urandom_range(1, 3)) : L;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        if ($urandom_range(0, 9) == 0) begin
          cfg_nfft  = 4'($urandom_range(0, 4));
          cfg_nkeep = 16'($urandom_range(0, 20));
        end
        send($urandom, i == n - 1);
      end
    end
    drain();
    chk("random_errs", {err_early, err_late}, {m_early, m_late});
`ifdef CHIRP_DEFRAMER_FRAME_CNT_EN
    chk("random_frame_cnt", frame_cnt, 64'(exp_fc));
`endif

    // Reset mid-frame with beats buffered
    mode = 0; lat_chk = 1;
    do_reset();
    cfg_nfft = 4'd3; cfg_nkeep = 16'd0;
    send(32'hA00, 1'b0);
    send(32'hA01, 1'b0);
    mode = 3; m_axis_tready = 1'b0;
    send(32'hA02, 1'b0);
    mode = 0;
    do_reset();
    n0 = n_out;
    send_frame(8, 7, 32'hB00);
    drain();
    chk("post_reset_count", n_out - n0, 8);
`ifdef CHIRP_DEFRAMER_FRAME_CNT_EN
    chk("post_reset_frame_cnt", frame_cnt, 64'(exp_fc));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
